demod_integrator: RTL and testbench
===================================

// Module: demod_integrator
// PURPOSE
//  Digital down-conversion and boxcar integration stage directly downstream of sampler.
//  Each clk100 beat carries 5 parallel lanes. Per lane it consumes shifted I/Q and a 14-bit phase.
//  It rotates I/Q by the phase using cos/sin and sums the 5 lanes.
//  It accumulates over sample_length beats, then presents one integrated I/Q point for qubit-state discrimination.
// PARAMETERS
//  LANES      5   parallel samples per clock
//  DW         16  signed I/Q sample width
//  PW         14  phase width (full turn = 2^PW)
//  TW         16  signed trig width, Q1.15, +32767 max (never +32768)
//  LUT_AW     10  trig table address bits; index = phase[PW-1:PW-LUT_AW]
//  ACC_W      48  signed accumulator/output width
// PORTS
//  clk100         in   1             system clock, 100 MHz
//  reset_n        in   1             asynchronous, active-low reset
//  start          in   1             pulse: begin integration window (accepted only in IDLE)
//  sample_length  in   11            beats to integrate; latched on start
//  in_valid       in   1             lanes below carry a valid beat
//  data_i_shift   in   LANES*DW      signed I per lane, lane0 in LSBs
//  data_q_shift   in   LANES*DW      signed Q per lane
//  phase_vals     in   LANES*PW      unsigned phase per lane
//  busy           out  1             high from accepted start until result_valid
//  result_valid   out  1             one-cycle pulse, result ready
//  result_i       out  ACC_W         signed integrated rotated I; held until next result_valid
//  result_q       out  ACC_W         signed integrated rotated Q; held until next result_valid
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; result_valid=0; result_i=result_q=0; pipeline valids=0; counters=0.
//  Per lane: Ir = I*cos + Q*sin, Qr = Q*cos - I*sin. Products are full 32-bit signed.
//  Lane sum is 35-bit signed. The accumulator is sign-extended to ACC_W. There is no truncation and no saturation.
//  Pipeline:
//   - P1 registers the LUT outputs and the aligned I/Q.
//   - P2 registers the products.
//   - P3 registers the lane sums.
//   - in_valid travels through a 3-deep valid shift register.
//   - Fixed latency: in_valid beat to accumulator update = 3 cycles.
//  FSM:
//   - IDLE: on start, latch len=sample_length, clear acc and beat counter, go to ARM.
//     If sample_length=0, go to DONE instead.
//   - ARM/ACCUM (single state ACCUM): count accepted in_valid beats at pipeline input until count==len.
//     Further in_valid is ignored for this window. Go to FLUSH.
//   - FLUSH: wait until all 3 pipeline valids are clear, i.e. the last accepted beat has accumulated. Then go to DONE.
//   - DONE: result_i/q <= acc; result_valid=1 for this cycle; go to IDLE.
//  Each beat is tagged at pipeline entry with an "in-window" bit. Only tagged beats accumulate.
//  Untagged beats (arriving while IDLE/FLUSH) never reach acc.
//  start while busy is ignored and has no effect on len or acc.
//  start and in_valid in the same IDLE cycle: that beat is the first beat of the window.
//  sample_length=0: result_valid 2 cycles after start, result=0.
//  Max len 2047: worst case |acc| < 2^46, so it fits ACC_W.
//  Gaps in in_valid are allowed. The window counts valid beats, not cycles.
//  Asynchronous reset mid-window: all state and outputs go to reset values immediately. No result is produced.
//  Trig table: cos[k] = round(32767*cos(2*pi*k/2^LUT_AW)), same for sin. Values are clamped to [-32767, 32767].
// STRUCTURE
//  Shared package qubit_pkg: LANES, DW, PW, TW, ACC_W; typedef lane_iq_t, phase_t; enum demod_state_t {IDLE,ACCUM,FLUSH,DONE}.
//  Sub-module trig_lut: registered cos/sin ROM, 1 cycle latency. One instance per lane; initialised from generated table.
//  Top: lane generate loop (trig_lut + 4 multipliers), adder tree, FSM/counter, accumulator.
// TESTING
//  1. Phase=0 all lanes, I=100, Q=0, len=4, 4 contiguous valids -> result_i=65,534,000, result_q=0, one result_valid pulse.
//  2. Phase=4096 (90 deg), I=100, Q=0, len=4 -> result_i=0, result_q=-65,534,000.
//  3. len=0 start -> busy for 2 cycles, result_valid with result_i=result_q=0; in_valid traffic is ignored.
//  4. Phase=0, I=1, len=3, in_valid pattern 1,0,1,0,1,1,1 -> exactly 3 beats summed: result_i=491,505, trailing beats excluded.
//  5. Second start mid-window and in_valid before start -> ignored; result matches the clean run of scenario 1.
//  6. Reset_n low during ACCUM, then release and rerun scenario 1 -> no spurious result_valid; outputs 0 during reset; rerun result correct.
//  Also: random I/Q/phase, len=2047, compare against a bit-accurate reference model using the same LUT.

Source files
------------

// File: rtl/qubit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : qubit_pkg
//  Description : Shared widths, types and helpers for the readout demodulator
//  Revision    : 1.0 - initial release
// ============================================================================
package qubit_pkg;

  localparam int LANES  = 5;            // parallel samples per clock
  localparam int DW     = 16;           // signed I/Q sample width
  localparam int PW     = 14;           // phase width, full turn = 2^PW
  localparam int TW     = 16;           // signed Q1.15 trig width
  localparam int LUT_AW = 10;           // trig table address bits
  localparam int ACC_W  = 48;           // accumulator / result width
  localparam int LEN_W  = 11;           // window length width
  localparam int PROD_W = DW + TW;      // full-precision product
  localparam int SUM_W  = PROD_W + 3;   // five lanes of (a*b + c*d)
  localparam int LUT_N  = 1 << LUT_AW;

  typedef logic signed [DW-1:0] lane_iq_t;
  typedef logic [PW-1:0]        phase_t;
  typedef logic signed [TW-1:0] trig_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } demod_state_t;

  // Scale a unit-range real to Q1.15, round half away from zero, and clamp
  // symmetrically so +1.0 maps to +32767 rather than overflowing.
  function automatic trig_t q15_round(input real v);
    real r;
    int  iv;
    r = v * 32767.0;
    if (r >= 0.0) iv = $rtoi(r + 0.5);
    else          iv = -$rtoi(0.5 - r);
    if (iv > 32767)  iv = 32767;
    if (iv < -32767) iv = -32767;
    return trig_t'(iv);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_lut.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trig_lut
//  Description : Registered cos/sin ROM, one cycle latency, table built at
//                elaboration from a Taylor series evaluated in double precision
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_lut import qubit_pkg::*; (
  input  logic                    i_clk,
  input  logic [LUT_AW-1:0]       i_addr,
  output logic signed [TW-1:0]    o_cos,
  output logic signed [TW-1:0]    o_sin
);

  localparam real C_PI      = 3.14159265358979323846;
  localparam int  C_ENTRY_W = 2 * TW;

  // Each entry packs {sin, cos}. The angle is folded into [-pi, pi) so the
  // series converges quickly and stays well-conditioned.
  function automatic logic [LUT_N*C_ENTRY_W-1:0] gen_table();
    logic [LUT_N*C_ENTRY_W-1:0] tab;
    real x, x2, c, s, tc, ts;
    tab = '0;
    for (int k = 0; k < LUT_N; k++) begin
      x = 2.0 * C_PI * real'(k) / real'(LUT_N);
      if (k >= LUT_N / 2) x = x - 2.0 * C_PI;
      x2 = x * x;
      c  = 1.0;
      s  = x;
      tc = 1.0;
      ts = x;
      for (int n = 1; n <= 24; n++) begin
        tc = -tc * x2 / real'((2 * n - 1) * (2 * n));
        ts = -ts * x2 / real'((2 * n) * (2 * n + 1));
        c  = c + tc;
        s  = s + ts;
      end
      tab[k*C_ENTRY_W +: TW]      = q15_round(c);
      tab[k*C_ENTRY_W + TW +: TW] = q15_round(s);
    end
    return tab;
  endfunction

  localparam logic [LUT_N*C_ENTRY_W-1:0] C_TABLE = gen_table();

  // ROM read register
  always_ff @(posedge i_clk) begin
    o_cos <= C_TABLE[int'(i_addr)*C_ENTRY_W +: TW];
    o_sin <= C_TABLE[int'(i_addr)*C_ENTRY_W + TW +: TW];
  end

endmodule
`default_nettype wire

// File: rtl/demod_integrator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : demod_integrator
//  Description : Per-lane I/Q phase rotation, lane summation and boxcar
//                integration over a counted window of valid beats
//  Revision    : 1.0 - initial release
// ============================================================================
module demod_integrator import qubit_pkg::*; (
  input  logic                    clk100,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        sample_length,
  input  logic                    in_valid,
  input  logic [LANES*DW-1:0]     data_i_shift,
  input  logic [LANES*DW-1:0]     data_q_shift,
  input  logic [LANES*PW-1:0]     phase_vals,
  output logic                    busy,
  output logic                    result_valid,
  output logic [ACC_W-1:0]        result_i,
  output logic [ACC_W-1:0]        result_q
);

  demod_state_t               r_state;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_cnt;
  logic [LEN_W-1:0]           w_cnt_nxt;
  logic                       r_busy;
  logic                       r_result_valid;
  logic signed [ACC_W-1:0]    r_acc_i;
  logic signed [ACC_W-1:0]    r_acc_q;
  logic [ACC_W-1:0]           r_res_i;
  logic [ACC_W-1:0]           r_res_q;
  logic [2:0]                 r_vld;
  logic [2:0]                 r_tag;
  logic                       w_start_ok;
  logic                       w_take;
  logic                       w_tagged_out;
  logic                       w_flushed;

  logic [LANES*TW-1:0]        w_cos_flat;
  logic [LANES*TW-1:0]        w_sin_flat;
  logic [LANES*(PW-LUT_AW)-1:0] w_unused_phase_lsb;
  lane_iq_t                   r_p1_i [LANES];
  lane_iq_t                   r_p1_q [LANES];
  logic signed [PROD_W-1:0]   r_ic [LANES];
  logic signed [PROD_W-1:0]   r_qs [LANES];
  logic signed [PROD_W-1:0]   r_qc [LANES];
  logic signed [PROD_W-1:0]   r_is [LANES];
  logic signed [SUM_W-1:0]    w_sum_i;
  logic signed [SUM_W-1:0]    w_sum_q;
  logic signed [SUM_W-1:0]    r_sum_i;
  logic signed [SUM_W-1:0]    r_sum_q;

  // One trig ROM per lane, addressed by the phase MSBs; its read register
  // forms the trig half of P1.
  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      trig_lut u_trig_lut (
        .i_clk  (clk100),
        .i_addr (phase_vals[l*PW + (PW-LUT_AW) +: LUT_AW]),
        .o_cos  (w_cos_flat[l*TW +: TW]),
        .o_sin  (w_sin_flat[l*TW +: TW])
      );
      assign w_unused_phase_lsb[l*(PW-LUT_AW) +: (PW-LUT_AW)] = phase_vals[l*PW +: (PW-LUT_AW)];
    end
  endgenerate

  // Datapath: P1 aligns I/Q with the ROM, P2 holds products, P3 holds lane sums
  always_ff @(posedge clk100) begin
    for (int k = 0; k < LANES; k++) begin
      r_p1_i[k] <= data_i_shift[k*DW +: DW];
      r_p1_q[k] <= data_q_shift[k*DW +: DW];
      r_ic[k]   <= PROD_W'(r_p1_i[k]) * PROD_W'($signed(w_cos_flat[k*TW +: TW]));
      r_qs[k]   <= PROD_W'(r_p1_q[k]) * PROD_W'($signed(w_sin_flat[k*TW +: TW]));
      r_qc[k]   <= PROD_W'(r_p1_q[k]) * PROD_W'($signed(w_cos_flat[k*TW +: TW]));
      r_is[k]   <= PROD_W'(r_p1_i[k]) * PROD_W'($signed(w_sin_flat[k*TW +: TW]));
    end
    r_sum_i <= w_sum_i;
    r_sum_q <= w_sum_q;
  end

  // Lane adder: Ir = I*cos + Q*sin, Qr = Q*cos - I*sin, summed over lanes
  always_comb begin
    w_sum_i = '0;
    w_sum_q = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum_i = w_sum_i + SUM_W'(r_ic[k]) + SUM_W'(r_qs[k]);
      w_sum_q = w_sum_q + SUM_W'(r_qc[k]) - SUM_W'(r_is[k]);
    end
  end

  // A beat joins the window only while counting, or as the very first beat
  // alongside an accepted start of a non-empty window.
  assign w_start_ok   = start && (r_state == IDLE) && !r_busy;
  assign w_take       = in_valid && ((r_state == ACCUM) ||
                                     (w_start_ok && (sample_length != '0)));
  assign w_cnt_nxt    = r_cnt + LEN_W'(1);
  assign w_tagged_out = r_vld[2] & r_tag[2];
  // Only in-window beats hold up the flush, so stray traffic cannot stall it.
  assign w_flushed    = ((r_vld & r_tag) == 3'b000);

  // Valid and in-window tag shift registers tracking P1..P3
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld <= {r_vld[1:0], in_valid};
      r_tag <= {r_tag[1:0], w_take};
    end
  end

  // Window control FSM, beat counter and accumulator
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_acc_i        <= '0;
      r_acc_q        <= '0;
      r_res_i        <= '0;
      r_res_q        <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if (r_result_valid) r_busy <= 1'b0;
      if (w_tagged_out) begin
        r_acc_i <= r_acc_i + ACC_W'(r_sum_i);
        r_acc_q <= r_acc_q + ACC_W'(r_sum_q);
      end
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_busy  <= 1'b1;
            r_len   <= sample_length;
            r_acc_i <= '0;
            r_acc_q <= '0;
            if (sample_length == '0) begin
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_cnt   <= w_take ? LEN_W'(1) : '0;
              r_state <= (w_take && (sample_length == LEN_W'(1))) ? FLUSH : ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_flushed) r_state <= DONE;
        end
        DONE: begin
          r_res_i        <= r_acc_i;
          r_res_q        <= r_acc_q;
          r_result_valid <= 1'b1;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_i     = r_res_i;
  assign result_q     = r_res_q;

endmodule
`default_nettype wire

// File: tb/tb_demod_integrator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_demod_integrator
//  Description : Directed and randomised self-checking bench for
//                demod_integrator
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demod_integrator;
  import qubit_pkg::*;

  logic                  clk100 = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  start = 1'b0;
  logic [LEN_W-1:0]      sample_length = '0;
  logic                  in_valid = 1'b0;
  logic [LANES*DW-1:0]   data_i_shift = '0;
  logic [LANES*DW-1:0]   data_q_shift = '0;
  logic [LANES*PW-1:0]   phase_vals = '0;
  logic                  busy;
  logic                  result_valid;
  logic [ACC_W-1:0]      result_i;
  logic [ACC_W-1:0]      result_q;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int tb_cos [LUT_N];
  int tb_sin [LUT_N];

  demod_integrator dut (
    .clk100        (clk100),
    .reset_n       (reset_n),
    .start         (start),
    .sample_length (sample_length),
    .in_valid      (in_valid),
    .data_i_shift  (data_i_shift),
    .data_q_shift  (data_q_shift),
    .phase_vals    (phase_vals),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_i      (result_i),
    .result_q      (result_q)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) if (result_valid === 1'b1) n_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int iv, input int qv, input int ph);
    for (int l = 0; l < LANES; l++) begin
      data_i_shift[l*DW +: DW] = 16'(iv);
      data_q_shift[l*DW +: DW] = 16'(qv);
      phase_vals[l*PW +: PW]   = 14'(ph);
    end
  endtask

  task automatic wait_rv(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (result_valid === 1'b1) seen = 1'b1;
    end
    chk(tag, longint'(seen), 1);
  endtask

  // Four contiguous beats of a uniform lane pattern, start with the first beat.
  task automatic run_basic(input string tag, input int iv, input int qv, input int ph);
    set_all(iv, qv, ph);
    sample_length = 11'd4;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    wait_rv(tag, 40);
  endtask

  function automatic int rnd15(input real x);
    int v;
    if (x >= 0.0) v = $rtoi(x * 32767.0 + 0.5);
    else          v = -$rtoi(0.5 - x * 32767.0);
    if (v > 32767)  v = 32767;
    if (v < -32767) v = -32767;
    return v;
  endfunction

  initial begin
    int      p0;
    int      beats;
    longint  ei, eq;
    logic signed [DW-1:0] ri, rq;
    logic [PW-1:0]        rp;
    bit pat [7];

    for (int k = 0; k < LUT_N; k++) begin
      tb_cos[k] = rnd15($cos(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N)));
      tb_sin[k] = rnd15($sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N)));
    end

    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_rv", longint'(result_valid), 0);
    chk("reset_res_i", $signed(result_i), 0);
    chk("reset_res_q", $signed(result_q), 0);
    reset_n = 1'b1;
    tick();

    // 1: phase 0, I=100 -> 5 lanes * 4 beats * 100 * 32767
    p0 = n_pulses;
    run_basic("s1_rv", 100, 0, 0);
    chk("s1_res_i", $signed(result_i), 64'sd65534000);
    chk("s1_res_q", $signed(result_q), 0);
    repeat (4) tick();
    chk("s1_pulses", n_pulses - p0, 1);
    chk("s1_busy_after", longint'(busy), 0);

    // 2: 90 degrees, I=100 -> all energy moves to -Q
    run_basic("s2_rv", 100, 0, 4096);
    chk("s2_res_i", $signed(result_i), 0);
    chk("s2_res_q", $signed(result_q), -64'sd65534000);
    repeat (2) tick();

    // 2b: phase 0, Q=50 -> Ir=0, Qr=50*32767*20
    run_basic("s2b_rv", 0, 50, 0);
    chk("s2b_res_i", $signed(result_i), 0);
    chk("s2b_res_q", $signed(result_q), 64'sd32767000);
    repeat (2) tick();

    // 3: empty window with in_valid traffic
    set_all(100, 0, 0);
    p0 = n_pulses;
    sample_length = '0;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("s3_busy_c1", longint'(busy), 1);
    chk("s3_rv_c1", longint'(result_valid), 0);
    tick();
    chk("s3_busy_c2", longint'(busy), 1);
    chk("s3_rv_c2", longint'(result_valid), 1);
    chk("s3_res_i", $signed(result_i), 0);
    chk("s3_res_q", $signed(result_q), 0);
    tick();
    chk("s3_busy_c3", longint'(busy), 0);
    repeat (6) tick();
    in_valid = 1'b0;
    chk("s3_pulses", n_pulses - p0, 1);
    chk("s3_res_i_held", $signed(result_i), 0);

    // 4: gapped valids, len=3, trailing beats excluded
    set_all(1, 0, 0);
    sample_length = 11'd3;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[k];
      start = (k == 0);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_rv("s4_rv", 40);
    chk("s4_res_i", $signed(result_i), 64'sd491505);
    chk("s4_res_q", $signed(result_q), 0);
    repeat (2) tick();

    // 5: pre-start traffic, gap, and a stray start mid-window
    set_all(100, 0, 0);
    sample_length = 11'd4;
    in_valid = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("s5_busy_mid", longint'(busy), 1);
    in_valid = 1'b1;
    start = 1'b1;
    sample_length = 11'd1;
    tick();
    start = 1'b0;
    sample_length = 11'd4;
    repeat (2) tick();
    repeat (3) tick();
    in_valid = 1'b0;
    wait_rv("s5_rv", 40);
    chk("s5_res_i", $signed(result_i), 64'sd65534000);
    chk("s5_res_q", $signed(result_q), 0);
    repeat (2) tick();

    // 6: asynchronous reset in the middle of a window
    set_all(100, 0, 0);
    sample_length = 11'd4;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_busy", longint'(busy), 0);
    chk("s6_rst_rv", longint'(result_valid), 0);
    chk("s6_rst_res_i", $signed(result_i), 0);
    p0 = n_pulses;
    in_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    chk("s6_no_pulse", n_pulses - p0, 0);
    chk("s6_res_i_idle", $signed(result_i), 0);
    run_basic("s6_rerun_rv", 100, 0, 0);
    chk("s6_rerun_res_i", $signed(result_i), 64'sd65534000);
    chk("s6_rerun_res_q", $signed(result_q), 0);
    repeat (2) tick();

    // 7: random data, full-length window with random gaps vs reference model
    ei = 0;
    eq = 0;
    beats = 0;
    sample_length = 11'd2047;
    for (int k = 0; k < 20000 && beats < 2047; k++) begin
      in_valid = ($urandom_range(3) != 0) || (k == 0);
      start = (k == 0);
      for (int l = 0; l < LANES; l++) begin
        ri = 16'($urandom);
        rq = 16'($urandom);
        rp = 14'($urandom);
        data_i_shift[l*DW +: DW] = ri;
        data_q_shift[l*DW +: DW] = rq;
        phase_vals[l*PW +: PW]   = rp;
        if (in_valid) begin
          ei += longint'(ri) * tb_cos[rp[PW-1 -: LUT_AW]] + longint'(rq) * tb_sin[rp[PW-1 -: LUT_AW]];
          eq += longint'(rq) * tb_cos[rp[PW-1 -: LUT_AW]] - longint'(ri) * tb_sin[rp[PW-1 -: LUT_AW]];
        end
      end
      if (in_valid) beats++;
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("s7_beats", beats, 2047);
    wait_rv("s7_rv", 40);
    chk("s7_res_i", $signed(result_i), ei);
    chk("s7_res_q", $signed(result_q), eq);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
